logic_pipe_nbit: RTL and testbench
==================================

LOGIC_PIPE_NBIT -- requirements
Module: logic_pipe_nbit

Interface
REQ-001 Parameter N, default 8, operand/result width in bits (N >= 1).
REQ-002 Parameter DEPTH, default 2, number of pipeline register stages (DEPTH >= 1).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  operand set and op present.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port op  input  3  function select, encoding per REQ-013.
REQ-008 Ports in0, in1, in2  input  N each  operands.
REQ-009 Port out_valid  output  1  result present.
REQ-010 Port out_ready  input  1  consumer accepts result this cycle.
REQ-011 Port out  output  N  result.
REQ-012 Ports out_zero, out_ones  output  1 each  result all-0 / all-1 flags, qualified by out_valid.

Function
REQ-013 op encoding (bitwise per bit i): 000 NAND2(in0,in1); 001 NAND3; 010 AND3; 011 OR3; 100 NOR3; 101 XOR3 (odd parity of three); 110 MAJ3 (majority); 111 NOT in0.
REQ-014 For 2-input and 1-input ops, unused operands are ignored entirely.
REQ-015 Result computed combinationally from the accepted inputs, registered into stage 0; flags computed from that result at the same time and carried with it.
REQ-016 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-017 Each stage k holds valid_k, result, flags; the last stage drives out, out_zero, out_ones, and out_valid.
REQ-018 Stage k advances when stage k+1 is empty or advancing; the last stage advances when out_ready is high.
REQ-019 in_ready = !valid_0 || stage 0 advancing; full throughput of one result per cycle with out_ready held high.
REQ-020 Latency: an input accepted at edge t is presented at out with out_valid high after DEPTH edges when unstalled.
REQ-021 Stall: when out_ready is low and out_valid is high, out, out_zero, and out_ones hold stable until the transfer.
REQ-022 Full: with all stages valid and out_ready low, in_ready is 0; no input is dropped or overwritten.
REQ-023 Simultaneous: accept and emit in the same cycle is allowed when full and out_ready is high; occupancy stays unchanged.
REQ-024 Ordering is strictly FIFO; no reordering or duplication.
REQ-025 in0, in1, in2, and op are sampled only at acceptance; later changes do not affect in-flight results.
REQ-026 Result data in invalid stages is don't-care; out_zero and out_ones are don't-care when out_valid is 0.

Reset
REQ-027 While reset is high at an edge, all valid_k clear; out_valid is 0 and in_ready is 0 during reset.
REQ-028 Reset mid-operation discards all in-flight results; none appear after reset.
REQ-029 Data registers need no reset; in_ready rises in the first cycle after reset deasserts.

Structure
REQ-030 Shared package logic_pipe_pkg holds the op-code constants (OP_NAND2 through OP_NOT) and the op width.
REQ-031 One sub-module, logic_pipe_stage (a parametrised valid/data register with advance logic), is instantiated DEPTH times by generate.
REQ-032 The combinational function unit is built from per-bit gate instances in generate loops, consistent with the existing n-bit gate library.

Verification
REQ-033 With N=4, DEPTH=2, out_ready=1, sending in0=1011, in1=1110, in2=1101 with op=001 SHALL produce out=0111 two edges later, with zero=0 and ones=0.
REQ-034 Sending op=000 with in0=1111, in1=1111 (in2 arbitrary) SHALL produce out=0000 and out_zero=1; sending op=111 with in0=0000 SHALL produce out=1111 and out_ones=1.
REQ-035 Sending op=101 and then op=110 back-to-back with in0=1010, in1=1100, in2=0110 SHALL produce out=0000 and then out=1110 on consecutive cycles.
REQ-036 Holding out_ready=0 while sending 3 transactions SHALL make in_ready go 0 after 2 transactions, keep out stable, and, once out_ready=1, emit all 3 in order.
REQ-037 Asserting reset for 1 cycle with 2 results in flight SHALL give out_valid=0 on the next cycle, emit no stale result, and raise in_ready the cycle after reset.
REQ-038 A random op/operand stream with random out_ready, checked against a reference model, SHALL give results in FIFO order and no loss in 10,000 transactions.

Source files
------------

// File: rtl/logic_pipe_pkg.sv
// Shared op-code constants and widths for the n-bit logic pipeline.
package logic_pipe_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NAND2 = 3'b000;
    localparam logic [OP_W-1:0] OP_NAND3 = 3'b001;
    localparam logic [OP_W-1:0] OP_AND3  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR3   = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR3  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR3  = 3'b101;
    localparam logic [OP_W-1:0] OP_MAJ3  = 3'b110;
    localparam logic [OP_W-1:0] OP_NOT   = 3'b111;
endpackage

// File: rtl/logic_pipe_bitfn.sv
// One-bit function cell: selects one of eight gate functions of three inputs.
module logic_pipe_bitfn
    import logic_pipe_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic            c,
    input  logic [OP_W-1:0] op,
    output logic            y
);
    always_comb begin
        case (op)
            OP_NAND2: y = ~(a & b);
            OP_NAND3: y = ~(a & b & c);
            OP_AND3:  y = a & b & c;
            OP_OR3:   y = a | b | c;
            OP_NOR3:  y = ~(a | b | c);
            OP_XOR3:  y = a ^ b ^ c;
            OP_MAJ3:  y = (a & b) | (a & c) | (b & c);
            default:  y = ~a;
        endcase
    end
endmodule

// File: rtl/logic_pipe_stage.sv
// One elastic pipeline register: holds a valid bit and a data word, and
// accepts new data whenever it is empty or its contents move downstream.
module logic_pipe_stage #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         dn_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ready
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        ready   = !valid_q || dn_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (ready) begin
            valid_d = up_valid;
            if (up_valid) data_d = up_data;
        end
    end

    // Only the valid bit is reset; data in an empty stage is never observed.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/logic_pipe_nbit.sv
// N-bit three-operand logic unit feeding a DEPTH-stage valid/ready pipeline;
// each stage carries the result together with its all-zero / all-one flags.
module logic_pipe_nbit
    import logic_pipe_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    in0,
    input  logic [N-1:0]    in1,
    input  logic [N-1:0]    in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out,
    output logic            out_zero,
    output logic            out_ones
);
    localparam int W = N + 2;

    logic [N-1:0]            res;
    logic [W-1:0]            res_pkt;
    logic [DEPTH-1:0]        stg_valid;
    logic [DEPTH-1:0][W-1:0] stg_data;
    logic [DEPTH:0]          stg_ready;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            logic_pipe_bitfn u_fn (
                .a  (in0[i]),
                .b  (in1[i]),
                .c  (in2[i]),
                .op (op),
                .y  (res[i])
            );
        end
    endgenerate

    assign res_pkt = {&res, ~|res, res};
    assign stg_ready[DEPTH] = out_ready;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stg
            logic         up_valid;
            logic [W-1:0] up_data;
            if (k == 0) begin : g_head
                assign up_valid = in_valid;
                assign up_data  = res_pkt;
            end else begin : g_body
                assign up_valid = stg_valid[k-1];
                assign up_data  = stg_data[k-1];
            end
            logic_pipe_stage #(.W(W)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .up_valid (up_valid),
                .up_data  (up_data),
                .dn_ready (stg_ready[k+1]),
                .valid    (stg_valid[k]),
                .data     (stg_data[k]),
                .ready    (stg_ready[k])
            );
        end
    endgenerate

    // Hold off producers while reset is asserted even though all stages are empty.
    assign in_ready  = stg_ready[0] && !reset;
    assign out_valid = stg_valid[DEPTH-1];
    assign out       = stg_data[DEPTH-1][N-1:0];
    assign out_zero  = stg_data[DEPTH-1][N];
    assign out_ones  = stg_data[DEPTH-1][N+1];
endmodule

// File: tb/tb_logic_pipe_nbit.sv
// Directed and randomized checks of logic_pipe_nbit at N=4, DEPTH=2.
module tb_logic_pipe_nbit;
    localparam int N   = 4;
    localparam int NTX = 10000;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] in0, in1, in2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         out_zero, out_ones;

    int tests = 0;
    int fails = 0;

    logic_pipe_nbit #(.N(N), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_zero  (out_zero),
        .out_ones  (out_ones)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] c);
        in_valid = v; op = o; in0 = a; in1 = b; in2 = c;
    endtask

    // Reference: per-bit count of ones among the three operands.
    function automatic logic [N-1:0] ref_fn(input logic [2:0] o, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic [N-1:0] c);
        logic [N-1:0] r;
        for (int j = 0; j < N; j++) begin
            int cnt;
            cnt = int'(a[j]) + int'(b[j]) + int'(c[j]);
            case (o)
                3'd0: r[j] = !(a[j] && b[j]);
                3'd1: r[j] = (cnt != 3);
                3'd2: r[j] = (cnt == 3);
                3'd3: r[j] = (cnt != 0);
                3'd4: r[j] = (cnt == 0);
                3'd5: r[j] = (cnt % 2 == 1);
                3'd6: r[j] = (cnt >= 2);
                default: r[j] = !a[j];
            endcase
        end
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b1, 3'd0, 4'h0, 4'h0, 4'h0);
        tick; tick;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        tick;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_nand3;
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 4'b1011, 4'b1110, 4'b1101);
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL nand3_early: out_valid got %b want 0", out_valid); end
        tick;
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b0111 || out_zero !== 1'b0 || out_ones !== 1'b0) begin
            fails++;
            $display("FAIL nand3: got v=%b out=%b z=%b o=%b want v=1 out=0111 z=0 o=0", out_valid, out, out_zero, out_ones);
        end
        tick;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL nand3_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_flags;
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 4'b1111, 4'b1111, 4'b0101);
        tick;
        drive(1'b1, 3'b111, 4'b0000, 4'b1010, 4'b0110);
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b0000 || out_zero !== 1'b1 || out_ones !== 1'b0) begin
            fails++;
            $display("FAIL nand2_zero: got v=%b out=%b z=%b o=%b want v=1 out=0000 z=1 o=0", out_valid, out, out_zero, out_ones);
        end
        tick;
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b1111 || out_zero !== 1'b0 || out_ones !== 1'b1) begin
            fails++;
            $display("FAIL not_ones: got v=%b out=%b z=%b o=%b want v=1 out=1111 z=0 o=1", out_valid, out, out_zero, out_ones);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 4'b1010, 4'b1100, 4'b0110);
        tick;
        drive(1'b1, 3'b110, 4'b1010, 4'b1100, 4'b0110);
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b0000 || out_zero !== 1'b1) begin
            fails++;
            $display("FAIL b2b_xor3: got v=%b out=%b z=%b want v=1 out=0000 z=1", out_valid, out, out_zero);
        end
        tick;
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b1110 || out_zero !== 1'b0 || out_ones !== 1'b0) begin
            fails++;
            $display("FAIL b2b_maj3: got v=%b out=%b z=%b o=%b want v=1 out=1110 z=0 o=0", out_valid, out, out_zero, out_ones);
        end
        tick;
    endtask

    // A=AND3->1010, B=OR3->0111, C=NOR3->1100
    task automatic test_stall;
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 4'b1111, 4'b1010, 4'b1110);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_accept_a: in_ready got %b want 1", in_ready); end
        tick;
        drive(1'b1, 3'b011, 4'b0001, 4'b0010, 4'b0100);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_accept_b: in_ready got %b want 1", in_ready); end
        tick;
        drive(1'b1, 3'b100, 4'b0001, 4'b0010, 4'b0000);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_full: in_ready got %b want 0", in_ready); end
        for (int s = 0; s < 3; s++) begin
            tick;
            tests++;
            if (out_valid !== 1'b1 || out !== 4'b1010 || out_zero !== 1'b0 || out_ones !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b out=%b z=%b o=%b rdy=%b want v=1 out=1010 z=0 o=0 rdy=0",
                         s, out_valid, out, out_zero, out_ones, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_simul: in_ready got %b want 1", in_ready); end
        tick;
        drive(1'b0, 3'b111, 4'b1111, 4'b1111, 4'b1111);
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b0111) begin
            fails++; $display("FAIL stall_order_b: got v=%b out=%b want v=1 out=0111", out_valid, out);
        end
        tick;
        tests++;
        if (out_valid !== 1'b1 || out !== 4'b1100) begin
            fails++; $display("FAIL stall_order_c: got v=%b out=%b want v=1 out=1100", out_valid, out);
        end
        tick;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_empty: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        drive(1'b1, 3'b011, 4'b0001, 4'b0000, 4'b0000);
        tick;
        drive(1'b1, 3'b011, 4'b0010, 4'b0000, 4'b0000);
        tick;
        in_valid = 1'b0;
        reset = 1'b1;
        tick;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL midreset: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
        end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_rdy: in_ready got %b want 1", in_ready); end
        for (int s = 0; s < 4; s++) begin
            tick;
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_stale[%0d]: out_valid got %b want 0", s, out_valid); end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] q[$];
        logic [N-1:0] exp;
        int tx = 0, rx = 0, cyc = 0;
        while (rx < NTX && cyc < 60000) begin
            in_valid  = (tx < NTX) && ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            in0       = N'($urandom());
            in1       = N'($urandom());
            in2       = N'($urandom());
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_extra: unexpected result %b at cycle %0d", out, cyc);
                end else begin
                    exp = q.pop_front();
                    if (out !== exp || out_zero !== (exp == '0) || out_ones !== (exp == '1)) begin
                        fails++;
                        $display("FAIL rand_tx%0d: got out=%b z=%b o=%b want out=%b z=%b o=%b",
                                 rx, out, out_zero, out_ones, exp, exp == '0, exp == '1);
                    end
                end
                rx++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_fn(op, in0, in1, in2));
                tx++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        if (rx != NTX || tx != NTX) begin
            fails++; $display("FAIL rand_count: got sent=%0d recv=%0d want %0d each", tx, rx, NTX);
        end
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        drive(1'b0, 3'd0, '0, '0, '0);
        test_reset;
        test_nand3;
        test_flags;
        test_back_to_back;
        test_stall;
        test_reset_midflight;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
